// File: rtl/as_lookup_requester.sv
// Lookup initiator for the anti-spoof stage. It parses the module header and Ethernet/IPv4 keys,
// runs one CAM lookup handshake per packet and queues a forward/drop decision per packet.
module as_lookup_requester #(
    parameter int DATA_WIDTH          = 64,
    parameter int CTRL_WIDTH          = 8,
    parameter int NUM_OUTPUT_QUEUES   = 8,
    parameter int NUM_IQ_BITS         = 3,
    parameter int RES_FIFO_DEPTH_BITS = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic [CTRL_WIDTH-1:0]        in_ctrl,
    input  logic                         in_wr,
    output logic                         in_rdy,
    output logic [47:0]                  dst_mac,
    output logic [47:0]                  src_mac,
    output logic [31:0]                  dst_ip,
    output logic [31:0]                  src_ip,
    output logic [NUM_IQ_BITS-1:0]       src_port,
    output logic                         lookup_req,
    input  logic                         lookup_ack,
    input  logic [NUM_OUTPUT_QUEUES-1:0] dst_ports,
    input  logic                         lut_miss,
    input  logic                         lut_hit,
    output logic                         res_vld,
    output logic [NUM_OUTPUT_QUEUES-1:0] res_dst_ports,
    output logic                         res_drop,
    input  logic                         res_rd_en,
    output logic                         spoof_pkt,
    output logic                         runt_pkt
);

    localparam int DEPTH = 1 << RES_FIFO_DEPTH_BITS;
    localparam int CNT_W = RES_FIFO_DEPTH_BITS + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_PARSE, S_RUNT, S_WAIT_SPACE, S_REQ, S_SPOOF_WIN, S_WAIT_EOP
    } state_t;

    state_t                         state_reg;
    logic [2:0]                     word_cnt_reg;
    logic                           is_ipv4_reg;
    logic                           eop_seen_reg;
    logic                           spoof_seen_reg;
    logic                           miss_reg;
    logic                           win_cnt_reg;
    logic [NUM_OUTPUT_QUEUES-1:0]   ports_reg;

    logic [NUM_OUTPUT_QUEUES:0]     mem_reg [DEPTH];
    logic [RES_FIFO_DEPTH_BITS-1:0] rd_ptr_reg;
    logic [RES_FIFO_DEPTH_BITS-1:0] wr_ptr_reg;
    logic [RES_FIFO_DEPTH_BITS-1:0] rd_ptr_inc;
    logic [CNT_W-1:0]               count_reg;
    logic [CNT_W-1:0]               count_next;
    logic [NUM_OUTPUT_QUEUES:0]     push_entry;
    logic [NUM_OUTPUT_QUEUES:0]     head_next;
    logic                           fifo_push;
    logic                           fifo_pop;
    logic                           fifo_space;
    logic                           decision_drop;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts a push.
    always_comb begin
        fifo_pop      = res_rd_en && (count_reg != '0);
        fifo_space    = (count_reg != FULL_CNT) || fifo_pop;
        decision_drop = is_ipv4_reg && (spoof_seen_reg || lut_hit) && !miss_reg;
        fifo_push     = ((state_reg == S_RUNT) && fifo_space) ||
                        ((state_reg == S_SPOOF_WIN) && win_cnt_reg);
        push_entry    = (state_reg == S_RUNT) ? {1'b1, {NUM_OUTPUT_QUEUES{1'b0}}}
                                              : {decision_drop, ports_reg};
        rd_ptr_inc    = rd_ptr_reg + 1'b1;
        count_next    = count_reg + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        head_next     = {res_drop, res_dst_ports};
        if (count_next == '0)
            head_next = '0;
        else if ((count_reg == '0) || ((count_reg == CNT_W'(1)) && fifo_pop))
            head_next = push_entry;
        else if (fifo_pop)
            head_next = mem_reg[rd_ptr_inc];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            in_rdy         <= 1'b1;
            lookup_req     <= 1'b0;
            dst_mac        <= '0;
            src_mac        <= '0;
            dst_ip         <= '0;
            src_ip         <= '0;
            src_port       <= '0;
            word_cnt_reg   <= '0;
            is_ipv4_reg    <= 1'b0;
            eop_seen_reg   <= 1'b0;
            spoof_seen_reg <= 1'b0;
            miss_reg       <= 1'b0;
            win_cnt_reg    <= 1'b0;
            ports_reg      <= '0;
            spoof_pkt      <= 1'b0;
            runt_pkt       <= 1'b0;
        end else begin
            spoof_pkt <= 1'b0;
            runt_pkt  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (in_wr && (in_ctrl == {CTRL_WIDTH{1'b1}})) begin
                        src_port     <= in_data[16 +: NUM_IQ_BITS];
                        word_cnt_reg <= '0;
                        state_reg    <= S_PARSE;
                    end
                end
                S_PARSE: begin
                    if (in_wr) begin
                        if ((in_ctrl != '0) && (word_cnt_reg != 3'd4)) begin
                            state_reg <= S_RUNT;
                            in_rdy    <= 1'b0;
                        end else begin
                            word_cnt_reg <= word_cnt_reg + 3'd1;
                            case (word_cnt_reg)
                                3'd0: begin
                                    dst_mac        <= in_data[63:16];
                                    src_mac[47:32] <= in_data[15:0];
                                end
                                3'd1: begin
                                    src_mac[31:0] <= in_data[63:32];
                                    is_ipv4_reg   <= (in_data[31:16] == 16'h0800);
                                end
                                3'd3: begin
                                    src_ip        <= is_ipv4_reg ? in_data[47:16] : 32'h0;
                                    dst_ip[31:16] <= is_ipv4_reg ? in_data[15:0] : 16'h0;
                                end
                                3'd4: begin
                                    dst_ip[15:0] <= is_ipv4_reg ? in_data[63:48] : 16'h0;
                                    eop_seen_reg <= (in_ctrl != '0);
                                    state_reg    <= S_WAIT_SPACE;
                                    in_rdy       <= 1'b0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_RUNT: begin
                    if (fifo_space) begin
                        runt_pkt  <= 1'b1;
                        state_reg <= S_IDLE;
                        in_rdy    <= 1'b1;
                    end
                end
                // Space is reserved here so the decision push after the lookup never blocks.
                S_WAIT_SPACE: begin
                    if (fifo_space) begin
                        lookup_req <= 1'b1;
                        state_reg  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (lookup_ack) begin
                        ports_reg      <= dst_ports;
                        miss_reg       <= lut_miss;
                        lookup_req     <= 1'b0;
                        spoof_seen_reg <= 1'b0;
                        win_cnt_reg    <= 1'b0;
                        state_reg      <= S_SPOOF_WIN;
                    end
                end
                S_SPOOF_WIN: begin
                    if (!win_cnt_reg) begin
                        spoof_seen_reg <= spoof_seen_reg || lut_hit;
                        win_cnt_reg    <= 1'b1;
                    end else begin
                        spoof_pkt <= decision_drop;
                        state_reg <= eop_seen_reg ? S_IDLE : S_WAIT_EOP;
                        in_rdy    <= 1'b1;
                    end
                end
                S_WAIT_EOP: begin
                    if (in_wr && (in_ctrl != '0))
                        state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                    in_rdy    <= 1'b1;
                end
            endcase
        end
    end

    // Head of the decision FIFO is kept in output registers, updated from the next-state view.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            res_vld       <= 1'b0;
            res_dst_ports <= '0;
            res_drop      <= 1'b0;
        end else begin
            if (fifo_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (fifo_pop)
                rd_ptr_reg <= rd_ptr_inc;
            count_reg <= count_next;
            res_vld   <= (count_next != '0);
            {res_drop, res_dst_ports} <= head_next;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push)
            mem_reg[wr_ptr_reg] <= push_entry;
    end

endmodule
